// File: rtl/calc_seq_pkg.sv
// -----------------------------------------------------------------------------
// calc_seq_pkg
// Shared definitions for the calc request sequencer.
//   - calc_cmd_t   : command encodings understood by the calc DUV
//   - calc_rsp_t   : response codes returned by the calc DUV
//   - port_state_t : per-port request FSM states
//   - glob_state_t : global run/drain/settle FSM states
// -----------------------------------------------------------------------------
package calc_seq_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_LSH = 4'd5,
        CMD_RSH = 4'd6
    } calc_cmd_t;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_OK   = 2'd1,
        RSP_OVF  = 2'd2,
        RSP_INV  = 2'd3
    } calc_rsp_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_CMD,
        P_ARG2,
        P_WAIT,
        P_RESP
    } port_state_t;

    typedef enum logic [1:0] {
        G_RUN,
        G_DRAIN,
        G_SETTLE
    } glob_state_t;

endpackage

// File: rtl/calc_seq_port.sv
// -----------------------------------------------------------------------------
// calc_seq_port
// One calc request port: drives the two-cycle request protocol, waits for the
// DUV response with a timeout, and holds the result until the arbiter takes it.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               vector handshake targeted at this port (only while idle)
//   start_cmd/arg1/arg2 vector fields captured on start
//   duv_resp, duv_data  DUV response code / result for this port
//   grant               arbiter selects this port's result this cycle
//   idle                port is in IDLE
//   pending             port is in RESP, holding a result
//   req_cmd, req_data   registered request outputs toward the DUV
//   res_code/data/timeout  latched result fields
//   err_spurious        sticky flag: response seen in IDLE, CMD or ARG2
// -----------------------------------------------------------------------------
module calc_seq_port
    import calc_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CMD_W-1:0]  start_cmd,
    input  logic [DATA_W-1:0] start_arg1,
    input  logic [DATA_W-1:0] start_arg2,
    input  logic [1:0]        duv_resp,
    input  logic [DATA_W-1:0] duv_data,
    input  logic              grant,
    output logic              idle,
    output logic              pending,
    output logic [CMD_W-1:0]  req_cmd,
    output logic [DATA_W-1:0] req_data,
    output logic [1:0]        res_code,
    output logic [DATA_W-1:0] res_data,
    output logic              res_timeout,
    output logic              err_spurious
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    port_state_t       state;
    logic [DATA_W-1:0] arg2_q;
    logic [7:0]        wait_cnt;
    logic              resp_seen;

    assign resp_seen = (duv_resp != RSP_NONE);
    assign idle      = (state == P_IDLE);
    assign pending   = (state == P_RESP);

    // Request FSM. arg2 is captured at the handshake so the vector source is
    // free the very next cycle. The wait counter is 1 in the first WAIT cycle,
    // so the timeout fires in WAIT cycle TIMEOUT; a response in that same
    // cycle is checked first and therefore wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= P_IDLE;
            req_cmd      <= '0;
            req_data     <= '0;
            arg2_q       <= '0;
            wait_cnt     <= '0;
            res_code     <= '0;
            res_data     <= '0;
            res_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (resp_seen && (state == P_IDLE || state == P_CMD || state == P_ARG2)) begin
                err_spurious <= 1'b1;
            end
            case (state)
                P_IDLE: begin
                    if (start) begin
                        state    <= P_CMD;
                        req_cmd  <= start_cmd;
                        req_data <= start_arg1;
                        arg2_q   <= start_arg2;
                    end
                end
                P_CMD: begin
                    state    <= P_ARG2;
                    req_cmd  <= CMD_W'(CMD_NOP);
                    req_data <= arg2_q;
                end
                P_ARG2: begin
                    state    <= P_WAIT;
                    req_cmd  <= CMD_W'(CMD_NOP);
                    req_data <= '0;
                    wait_cnt <= 8'd1;
                end
                P_WAIT: begin
                    if (resp_seen) begin
                        state       <= P_RESP;
                        res_code    <= duv_resp;
                        res_data    <= duv_data;
                        res_timeout <= 1'b0;
                    end else if (wait_cnt >= TIMEOUT_CNT) begin
                        state       <= P_RESP;
                        res_code    <= RSP_NONE;
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                P_RESP: begin
                    if (grant) begin
                        state <= P_IDLE;
                    end
                end
                default: state <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/calc_req_sequencer.sv
// -----------------------------------------------------------------------------
// calc_req_sequencer
// Accepts {port, cmd, arg1, arg2} test vectors over valid/ready, drives the
// calc request protocol on NUM_PORTS ports, returns results on a single
// fixed-priority response channel and runs the drain/settle sequence that
// toggles test_change at the end of a test.
//
// Optional build macro: CALC_SEQ_SERIAL_EN
//   defined   -> at most one outstanding request across all ports
//   undefined -> one outstanding request per port, ports fully concurrent
//
// Ports:
//   c_clk, reset              clock, synchronous active-high reset
//   vec_valid/vec_ready       vector handshake
//   vec_port/cmd/arg1/arg2    vector fields
//   drain                     single-cycle end-of-test pulse
//   req_cmd_out/req_data_out  per-port requests, port p at slice p
//   out_resp/out_data         per-port DUV responses
//   rsp_valid/port/code/data/timeout  arbitrated result channel
//   err_spurious              per-port sticky unexpected-response flags
//   test_change               toggles once per completed drain
// -----------------------------------------------------------------------------
module calc_req_sequencer
    import calc_seq_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int CMD_W      = 4,
    parameter int TIMEOUT    = 15,
    parameter int SETTLE_CYC = 4,
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic                          vec_valid,
    output logic                          vec_ready,
    input  logic [PORT_W-1:0]             vec_port,
    input  logic [CMD_W-1:0]              vec_cmd,
    input  logic [DATA_W-1:0]             vec_arg1,
    input  logic [DATA_W-1:0]             vec_arg2,
    input  logic                          drain,
    output logic [NUM_PORTS*CMD_W-1:0]    req_cmd_out,
    output logic [NUM_PORTS*DATA_W-1:0]   req_data_out,
    input  logic [NUM_PORTS*2-1:0]        out_resp,
    input  logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic                          rsp_valid,
    output logic [PORT_W-1:0]             rsp_port,
    output logic [1:0]                    rsp_code,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_timeout,
    output logic [NUM_PORTS-1:0]          err_spurious,
    output logic                          test_change
);

    localparam logic [15:0] SETTLE_LAST = (SETTLE_CYC > 1) ? 16'(SETTLE_CYC - 1) : 16'd0;

    glob_state_t             gstate;
    logic [15:0]             settle_cnt;
    logic [NUM_PORTS-1:0]    port_idle;
    logic [NUM_PORTS-1:0]    port_pending;
    logic [NUM_PORTS-1:0]    grant;
    logic [NUM_PORTS-1:0]    res_timeout;
    logic [1:0]              res_code [NUM_PORTS];
    logic [DATA_W-1:0]       res_data [NUM_PORTS];
    logic [(1<<PORT_W)-1:0]  idle_ext;
    logic                    accept;

    // vec_ready looks up the targeted port's idle flag. The idle vector is
    // zero-extended to the full index range so out-of-range ports read 0.
    always_comb begin
        idle_ext = '0;
        idle_ext[NUM_PORTS-1:0] = port_idle;
        vec_ready = !reset && (gstate == G_RUN) && idle_ext[vec_port];
`ifdef CALC_SEQ_SERIAL_EN
        vec_ready = vec_ready && (&port_idle);
`endif
    end

    assign accept = vec_valid && vec_ready;

    // One request engine per port; only the addressed port sees start.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calc_seq_port #(
            .DATA_W  (DATA_W),
            .CMD_W   (CMD_W),
            .TIMEOUT (TIMEOUT)
        ) u_port (
            .clk          (c_clk),
            .reset        (reset),
            .start        (accept && (vec_port == PORT_W'(p))),
            .start_cmd    (vec_cmd),
            .start_arg1   (vec_arg1),
            .start_arg2   (vec_arg2),
            .duv_resp     (out_resp[p*2 +: 2]),
            .duv_data     (out_data[p*DATA_W +: DATA_W]),
            .grant        (grant[p]),
            .idle         (port_idle[p]),
            .pending      (port_pending[p]),
            .req_cmd      (req_cmd_out[p*CMD_W +: CMD_W]),
            .req_data     (req_data_out[p*DATA_W +: DATA_W]),
            .res_code     (res_code[p]),
            .res_data     (res_data[p]),
            .res_timeout  (res_timeout[p]),
            .err_spurious (err_spurious[p])
        );
    end

    // Fixed-priority arbiter: scanning from the highest index down lets the
    // lowest pending port overwrite the selection. The result channel shows
    // the granted port's fields in the grant cycle and is all-zero otherwise.
    always_comb begin
        grant       = '0;
        rsp_valid   = 1'b0;
        rsp_port    = '0;
        rsp_code    = '0;
        rsp_data    = '0;
        rsp_timeout = 1'b0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (port_pending[p]) begin
                grant       = '0;
                grant[p]    = 1'b1;
                rsp_valid   = 1'b1;
                rsp_port    = PORT_W'(p);
                rsp_code    = res_code[p];
                rsp_data    = res_data[p];
                rsp_timeout = res_timeout[p];
            end
        end
    end

    // Drain sequencing. The DRAIN cycle in which all ports are first seen idle
    // counts as the first settle cycle, so test_change toggles SETTLE_CYC
    // cycles after the last port returns to IDLE, and RUN resumes with it.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            gstate      <= G_RUN;
            settle_cnt  <= '0;
            test_change <= 1'b0;
        end else begin
            case (gstate)
                G_RUN: begin
                    if (drain) begin
                        gstate <= G_DRAIN;
                    end
                end
                G_DRAIN: begin
                    if (&port_idle) begin
                        if (SETTLE_LAST == 16'd0) begin
                            test_change <= ~test_change;
                            gstate      <= G_RUN;
                        end else begin
                            settle_cnt <= 16'd1;
                            gstate     <= G_SETTLE;
                        end
                    end
                end
                G_SETTLE: begin
                    if (settle_cnt >= SETTLE_LAST) begin
                        test_change <= ~test_change;
                        gstate      <= G_RUN;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                default: gstate <= G_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_req_sequencer
// Directed bench for calc_req_sequencer with default parameters
// (NUM_PORTS=4, DATA_W=32, CMD_W=4, TIMEOUT=15, SETTLE_CYC=4).
// A table of single-request vectors covers the main request/response path;
// hand-written sequences cover arbitration, spurious responses, drain and
// reset. Honours CALC_SEQ_SERIAL_EN where the expected ready value differs.
// -----------------------------------------------------------------------------
module tb_calc_req_sequencer;
    import calc_seq_pkg::*;

    logic         c_clk = 1'b0;
    logic         reset = 1'b1;
    logic         vec_valid;
    logic         vec_ready;
    logic [1:0]   vec_port;
    logic [3:0]   vec_cmd;
    logic [31:0]  vec_arg1;
    logic [31:0]  vec_arg2;
    logic         drain;
    logic [15:0]  req_cmd_out;
    logic [127:0] req_data_out;
    logic [7:0]   out_resp;
    logic [127:0] out_data;
    logic         rsp_valid;
    logic [1:0]   rsp_port;
    logic [1:0]   rsp_code;
    logic [31:0]  rsp_data;
    logic         rsp_timeout;
    logic [3:0]   err_spurious;
    logic         test_change;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [1:0]  port;
        logic [3:0]  cmd;
        logic [31:0] arg1;
        logic [31:0] arg2;
        int          resp_at;
        logic [1:0]  code_in;
        logic [31:0] data_in;
        int          exp_lat;
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
        logic        exp_to;
    } vec_t;

    vec_t tbl [6];

    calc_req_sequencer dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .vec_valid    (vec_valid),
        .vec_ready    (vec_ready),
        .vec_port     (vec_port),
        .vec_cmd      (vec_cmd),
        .vec_arg1     (vec_arg1),
        .vec_arg2     (vec_arg2),
        .drain        (drain),
        .req_cmd_out  (req_cmd_out),
        .req_data_out (req_data_out),
        .out_resp     (out_resp),
        .out_data     (out_data),
        .rsp_valid    (rsp_valid),
        .rsp_port     (rsp_port),
        .rsp_code     (rsp_code),
        .rsp_data     (rsp_data),
        .rsp_timeout  (rsp_timeout),
        .err_spurious (err_spurious),
        .test_change  (test_change)
    );

    // Free-running 10 ns clock.
    always #5 c_clk = ~c_clk;

    // Hard stop in case a sequence stalls beyond all per-wait bounds.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 ns after the next rising edge; inputs are driven here and
    // outputs are sampled 1 ns later.
    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] port, input logic [3:0] cmd,
                                 input logic [31:0] a1, input logic [31:0] a2);
        vec_valid = 1'b1;
        vec_port  = port;
        vec_cmd   = cmd;
        vec_arg1  = a1;
        vec_arg2  = a2;
    endtask

    task automatic clearVector();
        vec_valid = 1'b0;
        vec_cmd   = '0;
        vec_arg1  = '0;
        vec_arg2  = '0;
    endtask

    task automatic driveResp(input int p, input logic [1:0] code, input logic [31:0] data);
        out_resp[p*2 +: 2]  = code;
        out_data[p*32 +: 32] = data;
    endtask

    task automatic clearResp();
        out_resp = '0;
        out_data = '0;
    endtask

    function automatic logic [3:0] cmd_of(input int p);
        return req_cmd_out[p*4 +: 4];
    endfunction

    function automatic logic [31:0] data_of(input int p);
        return req_data_out[p*32 +: 32];
    endfunction

    // One complete request through one port: handshake, CMD and ARG2 phases,
    // DUV response (or none) in WAIT cycle resp_at, then the result pulse.
    task automatic runVector(input vec_t v);
        int  lat;
        bit  seen;
        step();
        applyStimulus(v.port, v.cmd, v.arg1, v.arg2);
        #1;
        checkOutput("vec_ready_idle", 64'(vec_ready), 64'd1);
        step();
        clearVector();
        #1;
        checkOutput("cmd_phase_cmd", 64'(cmd_of(v.port)), 64'(v.cmd));
        checkOutput("cmd_phase_data", 64'(data_of(v.port)), 64'(v.arg1));
        step();
        #1;
        checkOutput("arg2_phase_cmd", 64'(cmd_of(v.port)), 64'd0);
        checkOutput("arg2_phase_data", 64'(data_of(v.port)), 64'(v.arg2));
        seen = 1'b0;
        lat  = 0;
        for (int t = 3; t <= 40 && !seen; t++) begin
            step();
            if (v.resp_at != 0 && t == v.resp_at + 2) driveResp(v.port, v.code_in, v.data_in);
            else clearResp();
            #1;
            if (rsp_valid) begin
                seen = 1'b1;
                lat  = t;
            end
        end
        clearResp();
        checkOutput("rsp_seen", 64'(seen), 64'd1);
        if (seen) begin
            checkOutput("rsp_latency", 64'(lat), 64'(v.exp_lat));
            checkOutput("rsp_port", 64'(rsp_port), 64'(v.port));
            checkOutput("rsp_code", 64'(rsp_code), 64'(v.exp_code));
            checkOutput("rsp_data", 64'(rsp_data), 64'(v.exp_data));
            checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(v.exp_to));
        end
        step();
        vec_port = v.port;
        #1;
        checkOutput("rsp_single_pulse", 64'(rsp_valid), 64'd0);
        checkOutput("port_ready_again", 64'(vec_ready), 64'd1);
    endtask

    initial begin
        int cnt;
        // Latency is counted from the handshake cycle: response in WAIT cycle k
        // gives rsp_valid k+3 cycles later; a timeout gives TIMEOUT+3 = 18.
        tbl[0] = '{2'd0, CMD_ADD, 32'hFFFF0000, 32'h0000FFFF, 3,  2'd1, 32'hFFFFFFFF, 6,  2'd1, 32'hFFFFFFFF, 1'b0};
        tbl[1] = '{2'd2, CMD_SUB, 32'h80000000, 32'h00000001, 0,  2'd0, 32'h0,        18, 2'd0, 32'h0,        1'b1};
        tbl[2] = '{2'd1, CMD_LSH, 32'h00000001, 32'h00000004, 1,  2'd1, 32'h00000010, 4,  2'd1, 32'h00000010, 1'b0};
        tbl[3] = '{2'd3, CMD_RSH, 32'h00000100, 32'h00000004, 15, 2'd2, 32'h00000010, 18, 2'd2, 32'h00000010, 1'b0};
        tbl[4] = '{2'd0, 4'hF,    32'hDEADBEEF, 32'h12345678, 14, 2'd3, 32'h0000ABCD, 17, 2'd3, 32'h0000ABCD, 1'b0};
        tbl[5] = '{2'd3, CMD_ADD, 32'h00000007, 32'h00000009, 0,  2'd0, 32'h0,        18, 2'd0, 32'h0,        1'b1};

        clearVector();
        vec_port = '0;
        drain    = 1'b0;
        clearResp();

        // Reset values while reset is held.
        step();
        step();
        #1;
        checkOutput("rst_req_cmd", 64'(req_cmd_out), 64'd0);
        checkOutput("rst_req_data_lo", req_data_out[63:0], 64'd0);
        checkOutput("rst_req_data_hi", req_data_out[127:64], 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_fields", {27'd0, rsp_port, rsp_code, rsp_timeout, rsp_data}, 64'd0);
        checkOutput("rst_err", 64'(err_spurious), 64'd0);
        checkOutput("rst_test_change", 64'(test_change), 64'd0);
        checkOutput("rst_vec_ready", 64'(vec_ready), 64'd0);
        step();
        reset = 1'b0;
        #1;
        checkOutput("post_rst_ready", 64'(vec_ready), 64'd1);

        // Table-driven single requests.
        for (int i = 0; i < 6; i++) runVector(tbl[i]);

        // Four ports in consecutive cycles, all responses in one cycle.
        for (int p = 0; p < 4; p++) begin
            step();
            applyStimulus(2'(p), CMD_ADD, 32'(p), 32'(p + 10));
            #1;
            checkOutput("burst_ready", 64'(vec_ready), 64'd1);
        end
        step();
        clearVector();
        step();
        step();
        for (int p = 0; p < 4; p++) driveResp(p, 2'd1, 32'h100 + 32'(p));
        #1;
        checkOutput("burst_no_early_rsp", 64'(rsp_valid), 64'd0);
        for (int p = 0; p < 4; p++) begin
            step();
            clearResp();
            #1;
            checkOutput("burst_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("burst_rsp_port", 64'(rsp_port), 64'(p));
            checkOutput("burst_rsp_data", 64'(rsp_data), 64'h100 + 64'(p));
        end
        step();
        #1;
        checkOutput("burst_done", 64'(rsp_valid), 64'd0);

        // Spurious response while port 1 is in ARG2.
        step();
        applyStimulus(2'd1, CMD_ADD, 32'd5, 32'd6);
        step();
        clearVector();
        step();
        driveResp(1, 2'd1, 32'd0);
        #1;
        checkOutput("spur_before", 64'(err_spurious), 64'd0);
        step();
        clearResp();
        #1;
        checkOutput("spur_set", 64'(err_spurious), 64'b0010);
        step();
        driveResp(1, 2'd1, 32'h77);
        step();
        clearResp();
        #1;
        checkOutput("spur_rsp_port", 64'(rsp_port), 64'd1);
        checkOutput("spur_rsp_data", 64'(rsp_data), 64'h77);
        repeat (3) step();
        #1;
        checkOutput("spur_sticky", 64'(err_spurious), 64'b0010);

        // Second vector to another port while port 0 is busy.
        step();
        applyStimulus(2'd0, CMD_SUB, 32'd1, 32'd1);
        step();
        clearVector();
        vec_port = 2'd1;
        #1;
`ifdef CALC_SEQ_SERIAL_EN
        checkOutput("serial_stall", 64'(vec_ready), 64'd0);
`else
        checkOutput("concurrent_ready", 64'(vec_ready), 64'd1);
`endif
        cnt = 0;
        while (!rsp_valid && cnt < 30) begin
            step();
            #1;
            cnt++;
        end
        checkOutput("busy_timeout_seen", 64'(rsp_valid), 64'd1);
        checkOutput("busy_timeout_flag", 64'(rsp_timeout), 64'd1);
        step();
        #1;
        checkOutput("ready_after_busy", 64'(vec_ready), 64'd1);

        // Drain with a handshake in the same cycle, two ports in WAIT.
        step();
        applyStimulus(2'd0, CMD_SUB, 32'd9, 32'd3);
        step();
        applyStimulus(2'd1, CMD_ADD, 32'd7, 32'd8);
        drain = 1'b1;
        #1;
        checkOutput("drain_hs_ready", 64'(vec_ready), 64'd1);
        step();
        clearVector();
        drain    = 1'b0;
        vec_port = 2'd2;
        #1;
        checkOutput("drain_ready_low", 64'(vec_ready), 64'd0);
        checkOutput("drain_accept_cmd", 64'(cmd_of(1)), 64'(CMD_ADD));
        step();
        step();
        driveResp(0, 2'd1, 32'hC);
        step();
        clearResp();
        #1;
        checkOutput("drain_rsp0_port", 64'(rsp_port), 64'd0);
        step();
        driveResp(1, 2'd2, 32'hF);
        step();
        clearResp();
        #1;
        checkOutput("drain_rsp1_valid", 64'(rsp_valid), 64'd1);
        checkOutput("drain_rsp1_code", 64'(rsp_code), 64'd2);
        for (int k = 8; k <= 11; k++) begin
            step();
            #1;
            checkOutput("settle_no_toggle", 64'(test_change), 64'd0);
            checkOutput("settle_ready_low", 64'(vec_ready), 64'd0);
        end
        step();
        #1;
        checkOutput("settle_toggle", 64'(test_change), 64'd1);
        checkOutput("settle_ready_back", 64'(vec_ready), 64'd1);

        // Reset while port 3 is in CMD.
        step();
        applyStimulus(2'd3, CMD_ADD, 32'h33, 32'h44);
        step();
        clearVector();
        vec_port = 2'd3;
        #1;
        checkOutput("abort_cmd_phase", 64'(cmd_of(3)), 64'(CMD_ADD));
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checkOutput("abort_cmd_cleared", 64'(cmd_of(3)), 64'd0);
        checkOutput("abort_data_cleared", 64'(data_of(3)), 64'd0);
        checkOutput("abort_err_cleared", 64'(err_spurious), 64'd0);
        checkOutput("abort_test_change", 64'(test_change), 64'd0);
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            #1;
            if (rsp_valid) cnt++;
        end
        checkOutput("abort_no_rsp", 64'(cnt), 64'd0);
        checkOutput("abort_port_ready", 64'(vec_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
